// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the generic pipeline-stage register: control-field
// layout of the RISC-V stage control word and the stage occupancy encoding.
package pipe_stage_skid_pkg;

  // opcode carries inst[6:2]; inst[1:0] is always 2'b11 and is not stored
  localparam int OPC_OFF  = 0;
  localparam int OPC_W    = 5;
  localparam int RS1_OFF  = OPC_OFF + OPC_W;
  localparam int RS1_W    = 5;
  localparam int RS2_OFF  = RS1_OFF + RS1_W;
  localparam int RS2_W    = 5;
  localparam int RD_OFF   = RS2_OFF + RS2_W;
  localparam int RD_W     = 5;
  localparam int RWE_OFF  = RD_OFF + RD_W;
  localparam int RWE_W    = 1;
  localparam int MWE_OFF  = RWE_OFF + RWE_W;
  localparam int MWE_W    = 1;
  localparam int WBS_OFF  = MWE_OFF + MWE_W;
  localparam int WBS_W    = 2;

  localparam int CTRL_W_FULL  = WBS_OFF + WBS_W;
  localparam int CTRL_W_IFID  = CTRL_W_FULL;
  localparam int CTRL_W_IDEX  = CTRL_W_FULL;
  localparam int CTRL_W_EXMEM = CTRL_W_FULL;
  localparam int CTRL_W_MEMWB = CTRL_W_FULL;

  // Occupancy doubles as the state encoding
  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One payload+control holding register. Control clear beats load so a
// squashed or drained entry never presents a live control word.
module pipe_stage_entry
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = CTRL_W_FULL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_ctrl
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [CTRL_WIDTH-1:0] r_ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_ctrl <= '0;
    end else begin
      if (i_clr) begin
        r_ctrl <= '0;
      end else if (i_load) begin
        r_ctrl <= i_ctrl;
        r_data <= i_data;
      end
    end
  end

  assign o_data = r_data;
  assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline-stage register with flush-to-bubble and an
// optional 2-entry skid buffer that registers the upstream ready.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid = 0
// ST_ONE   | main entry holds the oldest beat, out_valid = 1
// ST_TWO   | main + skid both full, in_ready = 0 (SKID_EN = 1 only)
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = CTRL_W_FULL,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [1:0]            occupancy
);

  state_t r_state;
  state_t w_next;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_load;
  logic w_main_from_skid;
  logic w_main_clr;
  logic w_skid_load;
  logic w_skid_clr;

  logic [DATA_WIDTH-1:0] w_main_data;
  logic [CTRL_WIDTH-1:0] w_main_ctrl;
  logic [DATA_WIDTH-1:0] w_skid_data;
  logic [CTRL_WIDTH-1:0] w_skid_ctrl;

  assign out_valid  = (r_state != ST_EMPTY);
  assign occupancy  = r_state;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_EMPTY;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_next = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      w_next = SKID_EN ? ST_TWO : ST_ONE;
          else if (!w_in_fire && w_out_fire) w_next = ST_EMPTY;
        end
        ST_TWO:   if (w_out_fire) w_next = ST_ONE;
        default:  w_next = ST_EMPTY;
      endcase
    end
  end

  // Clears are derived from the next state so flush and draining share one path
  always_comb begin
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_main_clr       = (w_next == ST_EMPTY);
    w_skid_clr       = (w_next != ST_TWO);
    case (r_state)
      ST_EMPTY: w_main_load = w_in_fire;
      ST_ONE: begin
        w_main_load = w_in_fire & w_out_fire;
        w_skid_load = w_in_fire & ~w_out_fire;
      end
      ST_TWO: begin
        w_main_load      = w_out_fire;
        w_main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_main_data = w_main_from_skid ? w_skid_data : in_data;
  assign w_main_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;

  pipe_stage_entry #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_main_load),
    .i_clr   (w_main_clr),
    .i_data  (w_main_data),
    .i_ctrl  (w_main_ctrl),
    .o_data  (out_data),
    .o_ctrl  (out_ctrl)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic r_in_ready;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_in_ready <= 1'b1;
        else          r_in_ready <= (w_next != ST_TWO);
      end

      assign in_ready = r_in_ready;

      pipe_stage_entry #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
      ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_skid_load),
        .i_clr   (w_skid_clr),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
      );
    end else begin : g_no_skid
      logic w_unused_skid;

      assign in_ready      = ~out_valid | out_ready;
      assign w_skid_data   = '0;
      assign w_skid_ctrl   = '0;
      assign w_unused_skid = w_skid_load ^ w_skid_clr;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline-stage register for the RISC-V core. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Carries an opaque data payload and a separate control field, using a valid/ready handshake.
- Supports stall by back-pressure and flush by bubble insertion. A flush forces the control field to zero, so a squashed instruction never writes the register file or memory.
- Optional 2-entry skid buffer registers the upstream ready path, so hazard-unit stall logic does not chain combinationally across stages.

Parameters:
- DATA_WIDTH, 64, payload bits (e.g. alu_out + dataB); never interpreted.
- CTRL_WIDTH, 24, control bits (opcode, rs1/rs2/rd, reg_write_en, mem_write_en, wb_sel); forced to 0 on flush/empty.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register, in_ready = ~out_valid | out_ready (combinational).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries and of the current input beat.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  DATA_WIDTH  upstream payload.
- in_ctrl  input  CTRL_WIDTH  upstream control.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts (low = stall).
- out_data  output  DATA_WIDTH  registered payload.
- out_ctrl  output  CTRL_WIDTH  registered control; 0 whenever out_valid = 0.
- occupancy  output  2  entries held (0..2; max 1 when SKID_EN = 0).

Behaviour:
- Reset is asynchronous on reset_n low. Reset values: out_valid = 0, out_data = 0, out_ctrl = 0, occupancy = 0, skid entry cleared. in_ready = 1 when SKID_EN = 1. Reset taken mid-transfer discards all held beats.
- Handshake:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - out_data and out_ctrl stay stable while out_valid = 1 and out_ready = 0.
- Latency is 1 cycle from an accepted input to out_valid. Sustained throughput is 1 beat/cycle when out_ready is held at 1.
- States for SKID_EN = 1:
  - EMPTY (occupancy 0).
  - ONE: main register full, out_valid = 1.
  - TWO: main and skid both full.
- State transitions:
  - EMPTY + input goes to ONE.
  - ONE + input, no output goes to TWO. The beat is written to the skid register.
  - ONE + input + output stays in ONE. The main register loads the new beat.
  - ONE + output only goes to EMPTY.
  - TWO + output goes to ONE. The main register loads from skid.
  - TWO, no output stays in TWO.
  - In_ready in TWO = 0; in all other states = 1. in_ready is driven directly from a flop.
- Ordering: beats leave in acceptance order. The skid entry always drains before any newer beat.
- Flush:
  - On the next edge: occupancy = 0, out_valid = 0, out_ctrl = 0.
  - The input beat presented in the same cycle is dropped; flush wins over in_valid.
  - out_data may keep stale payload; only out_ctrl is guaranteed zero.
  - Flush with out_valid & out_ready in the same cycle: that output beat counts as transferred, then everything clears.
- SKID_EN = 0: states EMPTY/ONE only; the skid register is not instantiated. in_ready = ~out_valid | out_ready.
- No width arithmetic. Payload and control pass bit-exact.

Decomposition:
- Shared package: stage control field layout as localparams (offsets and widths of opcode, rs1, rs2, rd, reg_write_en, mem_write_en, wb_sel), plus the derived CTRL_WIDTH per stage.
- Shared package: state encoding constants ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2.
- One natural sub-module, pipe_stage_entry: a DATA+CTRL register with load enable and synchronous control clear. Instantiate it as the main entry, plus the skid entry under a generate on SKID_EN.

Test Plan:
- Reset then stream: reset_n low 3 cycles, then in_valid = 1 with in_data 1,2,3,4 on consecutive cycles and out_ready = 1. Required: out_valid rises 1 cycle later, out_data 1,2,3,4 back-to-back, occupancy = 1, in_ready always 1.
- Stall fill (SKID_EN = 1): out_ready = 0, push A then B. Required: occupancy 1 then 2, in_ready = 0 on the cycle after B, and C is held off upstream. Release out_ready: A, B, C exit in order with no loss or duplication.
- Flush with skid full: state TWO holding ctrl 0x00_1234 / 0x00_5678, flush = 1 with in_valid = 1. Required next cycle: out_valid = 0, out_ctrl = 0, occupancy = 0, in_ready = 1, and the flushed input never appears.
- Flush with same-cycle output: out_valid = 1, out_ready = 1, flush = 1. Required: downstream counts the beat exactly once, then the stage is EMPTY.
- Async reset mid-stall: in state TWO, pulse reset_n low between clock edges. Required: all outputs go 0 immediately (no clock needed) and in_ready = 1 after release.
- SKID_EN = 0 regression: random in_valid/out_ready over 10k cycles against a scoreboard. Required: in-order, lossless delivery; occupancy ≤ 1; in_ready == ~out_valid | out_ready every cycle.
